// File: rtl/ogfx_vram_arbiter.sv
// Video-RAM arbiter: refresh backend (priority) vs graphic frontend, with burst-limited starvation guard.
// Optional macro OGFX_VRAM_ARB_STATS_EN adds a frontend stall counter (gfx_stall_cnt_o, stats_clr_i).
module ogfx_vram_arbiter #(
  parameter int unsigned AW            = 17,
  parameter int unsigned MAX_REF_BURST = 4
) (
  input  logic          mclk,
  input  logic          puc_rst_n,
  input  logic [AW-1:0] ref_addr_i,
  input  logic          ref_cen_i,
  output logic          ref_dout_rdy_nxt_o,
  input  logic [AW-1:0] gfx_addr_i,
  input  logic          gfx_cen_i,
  input  logic [1:0]    gfx_wen_i,
  input  logic [15:0]   gfx_din_i,
  output logic          gfx_dout_rdy_nxt_o,
`ifdef OGFX_VRAM_ARB_STATS_EN
  input  logic          stats_clr_i,
  output logic [15:0]   gfx_stall_cnt_o,
`endif
  output logic [AW-1:0] vid_ram_addr_o,
  output logic          vid_ram_cen_o,
  output logic [1:0]    vid_ram_wen_o,
  output logic [15:0]   vid_ram_din_o,
  input  logic [15:0]   vid_ram_dout_i,
  output logic [15:0]   ref_dout_o,
  output logic [15:0]   gfx_dout_o
);

  typedef enum logic [1:0] {OWN_NONE, OWN_REF, OWN_GFX} owner_e;

  localparam logic [3:0] MAX_BURST = 4'(MAX_REF_BURST);

  owner_e      owner_q, owner_d;
  logic        gfx_rd_q, gfx_rd_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic [15:0] gfx_dout_q;
  logic        ref_req, gfx_req, gnt_ref, gnt_gfx, gfx_ret;

  always_comb begin
    ref_req = ~ref_cen_i;
    gfx_req = ~gfx_cen_i;
    // Reset masks both grants so the RAM is idle while puc_rst_n is low.
    gnt_gfx = puc_rst_n & gfx_req & (~ref_req | (burst_cnt_q == MAX_BURST));
    gnt_ref = puc_rst_n & ref_req & ~gnt_gfx;

    vid_ram_cen_o  = 1'b1;
    vid_ram_wen_o  = 2'b11;
    vid_ram_addr_o = '0;
    vid_ram_din_o  = '0;
    if (gnt_ref) begin
      vid_ram_cen_o  = 1'b0;
      vid_ram_addr_o = ref_addr_i;
    end else if (gnt_gfx) begin
      vid_ram_cen_o  = 1'b0;
      vid_ram_addr_o = gfx_addr_i;
      vid_ram_wen_o  = gfx_wen_i;
      vid_ram_din_o  = gfx_din_i;
    end
    ref_dout_rdy_nxt_o = gnt_ref;
    gfx_dout_rdy_nxt_o = gnt_gfx;

    owner_d  = gnt_ref ? OWN_REF : (gnt_gfx ? OWN_GFX : OWN_NONE);
    gfx_rd_d = gnt_gfx & (gfx_wen_i == 2'b11);

    burst_cnt_d = burst_cnt_q;
    if (!gfx_req || gnt_gfx)
      burst_cnt_d = '0;
    else if (gnt_ref && (burst_cnt_q < MAX_BURST))
      burst_cnt_d = burst_cnt_q + 4'd1;

    // Frontend sees RAM data directly in the return cycle, then the held copy.
    gfx_ret    = puc_rst_n & (owner_q == OWN_GFX) & gfx_rd_q;
    gfx_dout_o = '0;
    if (gfx_ret)
      gfx_dout_o = vid_ram_dout_i;
    else if (puc_rst_n)
      gfx_dout_o = gfx_dout_q;
    ref_dout_o = vid_ram_dout_i;
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      owner_q     <= OWN_NONE;
      gfx_rd_q    <= 1'b0;
      burst_cnt_q <= '0;
      gfx_dout_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      gfx_rd_q    <= gfx_rd_d;
      burst_cnt_q <= burst_cnt_d;
      if (gfx_ret)
        gfx_dout_q <= vid_ram_dout_i;
    end
  end

`ifdef OGFX_VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr_i)
      stall_cnt_d = '0;
    else if (gfx_req && !gnt_gfx && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) stall_cnt_q <= '0;
    else            stall_cnt_q <= stall_cnt_d;
  end

  assign gfx_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ogfx_vram_arbiter.sv
// Directed self-checking bench for ogfx_vram_arbiter with a small behavioural RAM model.
module tb_ogfx_vram_arbiter;
  localparam int unsigned AW = 17;

  logic          mclk = 1'b0;
  logic          puc_rst_n;
  logic [AW-1:0] ref_addr_i, gfx_addr_i;
  logic          ref_cen_i, gfx_cen_i;
  logic [1:0]    gfx_wen_i;
  logic [15:0]   gfx_din_i;
  logic          ref_dout_rdy_nxt_o, gfx_dout_rdy_nxt_o;
  logic [AW-1:0] vid_ram_addr_o;
  logic          vid_ram_cen_o;
  logic [1:0]    vid_ram_wen_o;
  logic [15:0]   vid_ram_din_o, vid_ram_dout_i, ref_dout_o, gfx_dout_o;
`ifdef OGFX_VRAM_ARB_STATS_EN
  logic          stats_clr_i;
  logic [15:0]   gfx_stall_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [256];

  always #5 mclk = ~mclk;

  ogfx_vram_arbiter #(.AW(AW), .MAX_REF_BURST(4)) dut (
    .mclk               (mclk),
    .puc_rst_n          (puc_rst_n),
    .ref_addr_i         (ref_addr_i),
    .ref_cen_i          (ref_cen_i),
    .ref_dout_rdy_nxt_o (ref_dout_rdy_nxt_o),
    .gfx_addr_i         (gfx_addr_i),
    .gfx_cen_i          (gfx_cen_i),
    .gfx_wen_i          (gfx_wen_i),
    .gfx_din_i          (gfx_din_i),
    .gfx_dout_rdy_nxt_o (gfx_dout_rdy_nxt_o),
`ifdef OGFX_VRAM_ARB_STATS_EN
    .stats_clr_i        (stats_clr_i),
    .gfx_stall_cnt_o    (gfx_stall_cnt_o),
`endif
    .vid_ram_addr_o     (vid_ram_addr_o),
    .vid_ram_cen_o      (vid_ram_cen_o),
    .vid_ram_wen_o      (vid_ram_wen_o),
    .vid_ram_din_o      (vid_ram_din_o),
    .vid_ram_dout_i     (vid_ram_dout_i),
    .ref_dout_o         (ref_dout_o),
    .gfx_dout_o         (gfx_dout_o)
  );

  // Single-port RAM: read data registered, byte writes active low.
  always @(posedge mclk) begin
    if (!vid_ram_cen_o) begin
      if (vid_ram_wen_o == 2'b11)
        vid_ram_dout_i <= mem[vid_ram_addr_o[7:0]];
      else begin
        if (!vid_ram_wen_o[0]) mem[vid_ram_addr_o[7:0]][7:0]  <= vid_ram_din_o[7:0];
        if (!vid_ram_wen_o[1]) mem[vid_ram_addr_o[7:0]][15:8] <= vid_ram_din_o[15:8];
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset();
    puc_rst_n = 1'b0;
    ref_cen_i = 1'b0; gfx_cen_i = 1'b0;
    ref_addr_i = 17'h00010; gfx_addr_i = 17'h00020;
    gfx_wen_i = 2'b11; gfx_din_i = 16'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (vid_ram_cen_o !== 1'b1 || ref_dout_rdy_nxt_o !== 1'b0 || gfx_dout_rdy_nxt_o !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle[%0d]: cen=%b ref_rdy=%b gfx_rdy=%b, want 1/0/0", i, vid_ram_cen_o,
                 ref_dout_rdy_nxt_o, gfx_dout_rdy_nxt_o);
      end
    end
    tests++;
    if (gfx_dout_o !== 16'h0 || vid_ram_wen_o !== 2'b11) begin
      fails++;
      $display("FAIL reset_vals: gfx_dout=%h wen=%b, want 0000/11", gfx_dout_o, vid_ram_wen_o);
    end
    tick();
    puc_rst_n = 1'b1;
    #1;
    tests++;
    if (ref_dout_rdy_nxt_o !== 1'b1 || gfx_dout_rdy_nxt_o !== 1'b0 || vid_ram_addr_o !== 17'h00010
        || vid_ram_cen_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ref_rdy=%b gfx_rdy=%b addr=%h cen=%b, want 1/0/00010/0",
               ref_dout_rdy_nxt_o, gfx_dout_rdy_nxt_o, vid_ram_addr_o, vid_ram_cen_o);
    end
    tick();
    ref_cen_i = 1'b1; gfx_cen_i = 1'b1;
    tick();
  endtask

  task automatic test_read(input logic [16:0] a, input logic [15:0] exp);
    gfx_cen_i = 1'b0; gfx_addr_i = a; gfx_wen_i = 2'b11;
    #1;
    tests++;
    if (gfx_dout_rdy_nxt_o !== 1'b1 || ref_dout_rdy_nxt_o !== 1'b0 || vid_ram_addr_o !== a
        || vid_ram_cen_o !== 1'b0 || vid_ram_wen_o !== 2'b11) begin
      fails++;
      $display("FAIL read_grant: gfx_rdy=%b ref_rdy=%b addr=%h cen=%b wen=%b, want 1/0/%h/0/11",
               gfx_dout_rdy_nxt_o, ref_dout_rdy_nxt_o, vid_ram_addr_o, vid_ram_cen_o, vid_ram_wen_o, a);
    end
    tick();
    gfx_cen_i = 1'b1;
    #1;
    tests++;
    if (gfx_dout_o !== exp) begin
      fails++;
      $display("FAIL read_data: gfx_dout=%h want %h", gfx_dout_o, exp);
    end
    tick();
    tick();
    tests++;
    if (gfx_dout_o !== exp || vid_ram_cen_o !== 1'b1 || vid_ram_addr_o !== '0 || vid_ram_din_o !== '0) begin
      fails++;
      $display("FAIL read_hold: gfx_dout=%h cen=%b addr=%h din=%h, want %h/1/0/0", gfx_dout_o,
               vid_ram_cen_o, vid_ram_addr_o, vid_ram_din_o, exp);
    end
  endtask

  task automatic test_write();
    gfx_cen_i = 1'b0; gfx_addr_i = 17'h00040; gfx_wen_i = 2'b01; gfx_din_i = 16'hBEEF;
    #1;
    tests++;
    if (vid_ram_wen_o !== 2'b01 || vid_ram_din_o !== 16'hBEEF || vid_ram_cen_o !== 1'b0
        || vid_ram_addr_o !== 17'h00040 || gfx_dout_rdy_nxt_o !== 1'b1) begin
      fails++;
      $display("FAIL write_grant: wen=%b din=%h cen=%b addr=%h rdy=%b, want 01/beef/0/00040/1",
               vid_ram_wen_o, vid_ram_din_o, vid_ram_cen_o, vid_ram_addr_o, gfx_dout_rdy_nxt_o);
    end
    tick();
    gfx_cen_i = 1'b1; gfx_wen_i = 2'b11; gfx_din_i = 16'h0;
    #1;
    tests++;
    if (vid_ram_cen_o !== 1'b1 || gfx_dout_o !== 16'hA5C3) begin
      fails++;
      $display("FAIL write_after: cen=%b gfx_dout=%h, want 1/a5c3", vid_ram_cen_o, gfx_dout_o);
    end
    tick();
    // High byte written only: 0x1234 -> 0xBE34.
    test_read(17'h00040, 16'hBE34);
  endtask

  task automatic test_back_to_back();
    ref_cen_i = 1'b0; gfx_cen_i = 1'b0; ref_addr_i = 17'h1ABCD; gfx_addr_i = 17'h00077; gfx_wen_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      logic exp_gfx;
      if (i > 0) tick();
      #1;
      exp_gfx = (i % 5 == 4);
      tests++;
      if (gfx_dout_rdy_nxt_o !== exp_gfx || ref_dout_rdy_nxt_o !== !exp_gfx
          || vid_ram_addr_o !== (exp_gfx ? 17'h00077 : 17'h1ABCD)
          || (!exp_gfx && (vid_ram_wen_o !== 2'b11 || vid_ram_din_o !== 16'h0))) begin
        fails++;
        $display("FAIL burst[%0d]: gfx_rdy=%b ref_rdy=%b addr=%h wen=%b, want gfx_rdy=%b", i,
                 gfx_dout_rdy_nxt_o, ref_dout_rdy_nxt_o, vid_ram_addr_o, vid_ram_wen_o, exp_gfx);
      end
    end
    tick();
    ref_cen_i = 1'b1; gfx_cen_i = 1'b1;
    tick();
  endtask

  task automatic test_ref_stop();
    ref_cen_i = 1'b0; gfx_cen_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      tests++;
      if (ref_dout_rdy_nxt_o !== 1'b1) begin
        fails++;
        $display("FAIL stop_ref[%0d]: ref_rdy=%b want 1", i, ref_dout_rdy_nxt_o);
      end
    end
    tick();
    ref_cen_i = 1'b1;
    #1;
    tests++;
    if (gfx_dout_rdy_nxt_o !== 1'b1 || ref_dout_rdy_nxt_o !== 1'b0) begin
      fails++;
      $display("FAIL stop_gfx: gfx_rdy=%b ref_rdy=%b want 1/0", gfx_dout_rdy_nxt_o, ref_dout_rdy_nxt_o);
    end
    tick();
    ref_cen_i = 1'b0;
    // Burst count restarted at zero: four refresh grants before the next frontend grant.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      tests++;
      if (gfx_dout_rdy_nxt_o !== (i == 4)) begin
        fails++;
        $display("FAIL stop_restart[%0d]: gfx_rdy=%b want %b", i, gfx_dout_rdy_nxt_o, (i == 4));
      end
    end
    tick();
    ref_cen_i = 1'b1; gfx_cen_i = 1'b1;
    tick();
  endtask

`ifdef OGFX_VRAM_ARB_STATS_EN
  task automatic test_stats();
    stats_clr_i = 1'b1;
    tick();
    stats_clr_i = 1'b0;
    tests++;
    if (gfx_stall_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL stats_clr0: cnt=%0d want 0", gfx_stall_cnt_o);
    end
    ref_cen_i = 1'b0; gfx_cen_i = 1'b0;
    repeat (50) tick();
    ref_cen_i = 1'b1; gfx_cen_i = 1'b1;
    #1;
    tests++;
    if (gfx_stall_cnt_o !== 16'd40) begin
      fails++;
      $display("FAIL stats_count: cnt=%0d want 40", gfx_stall_cnt_o);
    end
    stats_clr_i = 1'b1;
    tick();
    stats_clr_i = 1'b0;
    tests++;
    if (gfx_stall_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL stats_clr: cnt=%0d want 0", gfx_stall_cnt_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h23] = 16'hA5C3;
    mem[8'h40] = 16'h1234;
    vid_ram_dout_i = 16'h5A5A;
`ifdef OGFX_VRAM_ARB_STATS_EN
    stats_clr_i = 1'b0;
`endif
    test_reset();
    test_read(17'h00123, 16'hA5C3);
    test_write();
    test_back_to_back();
    test_ref_stop();
`ifdef OGFX_VRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
